// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state encoding, default tick
// period and the largest 8-digit BCD value the external counter can hold.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } sw_state_e;

    localparam int unsigned TICK_CYCLES_DEFAULT = 500000;
    localparam logic [31:0] BCD_MAX = 32'h9999_9999;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_CYCLES counted cycles.
// Priority is clear > hold > run; hold keeps the phase so a pause loses no time.
module tick_prescaler
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic hold,
    input  logic clear,
    output logic tick
);

    localparam logic [31:0] LAST = 32'(TICK_CYCLES - 1);

    logic [31:0] cnt_reg;
    logic [31:0] cnt_next;
    logic        at_last;

    always_comb begin
        at_last  = (cnt_reg == LAST);
        tick     = run && !hold && !clear && at_last;
        cnt_next = cnt_reg;
        if (clear) begin
            cnt_next = '0;
        end else if (!hold && run) begin
            cnt_next = at_last ? '0 : cnt_reg + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: drives an external BCD counter through count_en/count_clr,
// freezes the display on lap, and parks in PAUSE with a sticky flag on overflow.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        lap_clr,
    input  logic [31:0] count_value,
    output logic        count_en,
    output logic        count_clr,
    output logic [31:0] disp_value,
    output logic        running,
    output logic        lap_active,
    output logic        ovf,
    output logic [1:0]  state_o
);

    sw_state_e   state_reg, state_next;
    logic [31:0] lap_reg, lap_next;
    logic        ovf_reg, ovf_next;
    logic        count_en_reg, count_en_next;
    logic        count_clr_reg, count_clr_next;

    logic is_running;
    logic at_max;
    logic tick;
    logic pre_hold;

    assign is_running = (state_reg == ST_RUN) || (state_reg == ST_LAP);
    assign at_max     = (count_value == BCD_MAX);
    // The press cycle itself does not advance the prescaler, so resume picks up
    // exactly where the press happened.
    assign pre_hold   = (state_reg == ST_PAUSE) || (is_running && start_stop);

    tick_prescaler #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (is_running),
        .hold  (pre_hold),
        .clear (state_reg == ST_IDLE),
        .tick  (tick)
    );

    always_comb begin
        state_next     = state_reg;
        lap_next       = lap_reg;
        ovf_next       = ovf_reg;
        count_en_next  = tick && !at_max;
        count_clr_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_stop) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (tick && at_max) begin
                    ovf_next   = 1'b1;
                    state_next = ST_PAUSE;
                end else if (start_stop) begin
                    state_next = ST_PAUSE;
                end else if (lap_clr) begin
                    lap_next   = count_value;
                    state_next = ST_LAP;
                end
            end
            ST_LAP: begin
                if (tick && at_max) begin
                    ovf_next   = 1'b1;
                    state_next = ST_PAUSE;
                end else if (start_stop) begin
                    state_next = ST_PAUSE;
                end else if (lap_clr) begin
                    state_next = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (start_stop) begin
                    state_next = ST_RUN;
                end else if (lap_clr) begin
                    state_next     = ST_IDLE;
                    count_clr_next = 1'b1;
                    ovf_next       = 1'b0;
                    lap_next       = '0;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            lap_reg       <= '0;
            ovf_reg       <= 1'b0;
            count_en_reg  <= 1'b0;
            count_clr_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            lap_reg       <= lap_next;
            ovf_reg       <= ovf_next;
            count_en_reg  <= count_en_next;
            count_clr_reg <= count_clr_next;
        end
    end

    assign count_en   = count_en_reg;
    assign count_clr  = count_clr_reg;
    assign ovf        = ovf_reg;
    assign running    = is_running;
    assign lap_active = (state_reg == ST_LAP);
    assign state_o    = state_reg;
    assign disp_value = (state_reg == ST_LAP) ? lap_reg : count_value;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 500000 (10 ms at 50 MHz), clk cycles per count tick, legal range 2..2^32-1.
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start_stop  input  1  single-cycle debounced press pulse.
REQ-005 SHALL have port lap_clr  input  1  single-cycle debounced press pulse.
REQ-006 SHALL have port count_value  input  32  live 8-digit BCD value from the external cascaded BCD counter.
REQ-007 SHALL have port count_en  output  1  one-cycle increment enable to the counter.
REQ-008 SHALL have port count_clr  output  1  one-cycle synchronous clear to the counter.
REQ-009 SHALL have port disp_value  output  32  BCD value for the 7-segment driver.
REQ-010 SHALL have port running  output  1  high in RUN or LAP.
REQ-011 SHALL have port lap_active  output  1  high in LAP.
REQ-012 SHALL have port ovf  output  1  sticky overflow flag.
REQ-013 SHALL have port state_o  output  2  current state encoding.

Function
REQ-014 SHALL implement states IDLE=0, RUN=1, LAP=2, PAUSE=3, with all transitions registered: an input pulse in cycle N takes effect in state at N+1.
REQ-015 SHALL transition IDLE to RUN on start_stop, and SHALL ignore lap_clr in IDLE.
REQ-016 SHALL transition RUN to PAUSE on start_stop; on lap_clr it SHALL latch count_value into lap_reg and go to LAP.
REQ-017 SHALL transition LAP to PAUSE on start_stop (display live again), and LAP to RUN on lap_clr (freeze released).
REQ-018 SHALL transition PAUSE to RUN on start_stop; on lap_clr it SHALL go to IDLE, assert count_clr for exactly one cycle (cycle N+1), and clear ovf and lap_reg.
REQ-019 SHALL give start_stop priority when start_stop and lap_clr coincide; lap_clr is dropped.
REQ-020 SHALL run the prescaler 0..TICK_CYCLES-1 only in RUN/LAP, assert count_en for one cycle when the prescaler equals TICK_CYCLES-1, and wrap it to 0.
REQ-021 SHALL hold the prescaler in PAUSE (resume without loss) and force it to 0 in IDLE.
REQ-022 SHALL cause the first count_en after IDLE-to-RUN to occur exactly TICK_CYCLES cycles after state becomes RUN.
REQ-023 SHALL, on a tick while count_value==32'h9999_9999, suppress count_en, set ovf, and go to PAUSE; ovf then remains set until the clear in REQ-018.
REQ-024 SHALL compute disp_value combinationally as lap_reg in LAP, else count_value (zero latency).
REQ-025 SHALL keep count_en and count_clr mutually exclusive, both registered outputs.

Reset
REQ-026 SHALL, on reset, set state=IDLE, prescaler=0, lap_reg=0, ovf=0, count_en=0, count_clr=0; running=0, lap_active=0.
REQ-027 SHALL let reset override any pending pulse, and SHALL produce no count_en the cycle after reset deasserts.

Structure
REQ-028 SHALL place the state encoding constants and TICK_CYCLES default in shared package stopwatch_pkg.
REQ-029 SHALL implement the prescaler as sub-module tick_prescaler (inputs run, hold, clear; output tick).

Verification (TICK_CYCLES=4)
REQ-030 SHALL verify: reset, then start_stop pulse -> state_o=1 next cycle, count_en pulses at cycles +4, +8, +12 relative to entering RUN.
REQ-031 SHALL verify: in RUN with count_value=32'h0000_0123, lap_clr -> lap_active=1 and disp_value stays 0x00000123 while count_value advances; second lap_clr -> disp_value tracks count_value.
REQ-032 SHALL verify: start_stop at prescaler=2 -> PAUSE, no count_en; start_stop again -> next count_en 2 cycles after re-entering RUN.
REQ-033 SHALL verify: PAUSE + lap_clr -> count_clr high exactly one cycle, state_o=0, ovf=0.
REQ-034 SHALL verify: count_value=32'h9999_9999 in RUN -> at tick, count_en stays 0, ovf=1, state_o=3.
REQ-035 SHALL verify: start_stop and lap_clr in the same cycle in RUN -> PAUSE, lap_active stays 0.
